bram_port_arbiter: RTL and testbench

//  Shares one BRAM port (addr/we/din/dout) between two requesters: m0 = CPU data port,
//  m1 = UART debug loader/reader. Round-robin arbitration with optional burst lock.

---
 rtl/bram_port_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares a single BRAM port between the CPU data port (m0) and the UART
// debug loader/reader (m1). Round-robin arbitration is used when both
// masters request. A master can lock the port for a burst, and a lock
// counter forces release so a stuck lock cannot starve the other side.
// Accepted accesses drive registered BRAM address, enable and data outputs.
// Read data comes back with a per-master valid pulse, delivered in accept
// order through a small shift pipe that tracks the BRAM read latency.
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 1,
  parameter int MAX_LOCK   = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    m0_req,
  input  logic                    m0_lock,
  input  logic [DATA_WIDTH/8-1:0] m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,

  input  logic                    m1_req,
  input  logic                    m1_lock,
  input  logic [DATA_WIDTH/8-1:0] m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,

  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH/8-1:0] bram_we,
  output logic [DATA_WIDTH-1:0]   bram_din,
  input  logic [DATA_WIDTH-1:0]   bram_dout
);

  localparam int WE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_LOCK - 1);

  // ARB: free arbitration; OWN0/OWN1: the named master holds a lock.
  typedef enum logic [1:0] {
    ARB  = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e                state_q, state_d;
  // Round-robin pointer: 0 favours m0, 1 favours m1 on a tie.
  logic                  rr_q, rr_d;
  logic [CNT_WIDTH-1:0]  lock_cnt_q, lock_cnt_d;

  logic                  gnt0, gnt1;
  logic                  acc0, acc1;
  logic                  lock_timeout;

  logic                  rd_new;
  logic                  rd_new_id;
  logic [RD_LAT:0]       pipe_v_q;
  logic [RD_LAT:0]       pipe_id_q;

  logic [ADDR_WIDTH-1:0] bram_addr_q;
  logic [WE_WIDTH-1:0]   bram_we_q;
  logic [DATA_WIDTH-1:0] bram_din_q;

  // Grant decode: the owner sees its own request, otherwise tie-break via rr.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      ARB: begin
        if (m0_req && m1_req) begin
          gnt0 = ~rr_q;
          gnt1 = rr_q;
        end else begin
          gnt0 = m0_req;
          gnt1 = m1_req;
        end
      end
      OWN0: gnt0 = m0_req;
      OWN1: gnt1 = m1_req;
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
  end

  // Grants are forced low while reset is held so nothing is accepted then.
  assign m0_gnt = rst_n & gnt0;
  assign m1_gnt = rst_n & gnt1;

  assign acc0 = m0_req & m0_gnt;
  assign acc1 = m1_req & m1_gnt;

  assign lock_timeout = (lock_cnt_q == CNT_LAST);

  // Next-state logic for ownership, the round-robin pointer and lock counter.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      ARB: begin
        lock_cnt_d = '0;
        if (acc0) begin
          rr_d = 1'b1;
          if (m0_lock) begin
            state_d = OWN0;
          end
        end else if (acc1) begin
          rr_d = 1'b0;
          if (m1_lock) begin
            state_d = OWN1;
          end
        end
      end
      OWN0: begin
        lock_cnt_d = lock_cnt_q + CNT_WIDTH'(1);
        if (lock_timeout) begin
          state_d    = ARB;
          lock_cnt_d = '0;
          rr_d       = 1'b1;
        end else if (!m0_lock) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end
      end
      OWN1: begin
        lock_cnt_d = lock_cnt_q + CNT_WIDTH'(1);
        if (lock_timeout) begin
          state_d    = ARB;
          lock_cnt_d = '0;
          rr_d       = 1'b0;
        end else if (!m1_lock) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ARB;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      rr_q       <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // BRAM port drive: load the accepted master's fields; idle cycles only drop we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_addr_q <= '0;
      bram_we_q   <= '0;
      bram_din_q  <= '0;
    end else if (acc0) begin
      bram_addr_q <= m0_addr;
      bram_we_q   <= m0_we;
      bram_din_q  <= m0_wdata;
    end else if (acc1) begin
      bram_addr_q <= m1_addr;
      bram_we_q   <= m1_we;
      bram_din_q  <= m1_wdata;
    end else begin
      bram_we_q   <= '0;
    end
  end

  assign bram_addr = bram_addr_q;
  assign bram_we   = bram_we_q;
  assign bram_din  = bram_din_q;

  // An accepted access with no byte enables is a read; tag it with its master.
  assign rd_new    = (acc0 && (m0_we == '0)) || (acc1 && (m1_we == '0));
  assign rd_new_id = acc1;

  // Read tracking pipe: the last stage lines up with BRAM data after RD_LAT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v_q  <= '0;
      pipe_id_q <= '0;
    end else begin
      pipe_v_q  <= {pipe_v_q[RD_LAT-1:0], rd_new};
      pipe_id_q <= {pipe_id_q[RD_LAT-1:0], rd_new_id};
    end
  end

  assign m0_rvalid = pipe_v_q[RD_LAT] & ~pipe_id_q[RD_LAT];
  assign m1_rvalid = pipe_v_q[RD_LAT] &  pipe_id_q[RD_LAT];

  assign m0_rdata = bram_dout;
  assign m1_rdata = bram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter
// Self-checking bench for bram_port_arbiter with a behavioural 1-cycle BRAM.
// Reads are predicted from a shadow memory and queued when accepted.
// A negedge monitor pops the queue when rvalid appears.
module tb_bram_port_arbiter;

  localparam int AW     = 16;
  localparam int DW     = 32;
  localparam int RD_LAT = 1;

  logic          clk;
  logic          rst_n;
  logic          m0_req, m0_lock, m0_gnt, m0_rvalid;
  logic [3:0]    m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_lock, m1_gnt, m1_rvalid;
  logic [3:0]    m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] bram_addr;
  logic [3:0]    bram_we;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sbq[$];
  exp_t          mon_e;
  logic [DW-1:0] bmem [0:255];
  logic [DW-1:0] smem [0:255];
  int            cyc     = 0;
  int            nerrors = 0;
  int            nchecks = 0;

  bram_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RD_LAT    (RD_LAT),
    .MAX_LOCK  (64)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0_req   (m0_req),
    .m0_lock  (m0_lock),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_gnt   (m0_gnt),
    .m0_rvalid(m0_rvalid),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_lock  (m1_lock),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_gnt   (m1_gnt),
    .m1_rvalid(m1_rvalid),
    .m1_rdata (m1_rdata),
    .bram_addr(bram_addr),
    .bram_we  (bram_we),
    .bram_din (bram_din),
    .bram_dout(bram_dout)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time read returns.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port BRAM with one cycle of read latency.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bram_we[b]) bmem[bram_addr[7:0]][8*b +: 8] <= bram_din[8*b +: 8];
    end
    bram_dout <= bmem[bram_addr[7:0]];
  end

  // Scoreboard monitor: every rvalid must match the oldest queued read.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m0_rvalid && m1_rvalid) begin
        nchecks++;
        nerrors++;
        $display("[TB] FAIL both_rvalid: m0_rvalid=%b m1_rvalid=%b required at most one", m0_rvalid, m1_rvalid);
      end
      if (m0_rvalid || m1_rvalid) begin
        nchecks++;
        if (sbq.size() == 0) begin
          nerrors++;
          $display("[TB] FAIL unexpected_rvalid: rvalid at cycle %0d with no read pending", cyc);
        end else begin
          mon_e = sbq.pop_front();
          if (m1_rvalid !== mon_e.id) begin
            nerrors++;
            $display("[TB] FAIL rvalid_id: got m1_rvalid=%b required %b", m1_rvalid, mon_e.id);
          end
          nchecks++;
          if (bram_dout !== mon_e.data || (mon_e.id ? m1_rdata : m0_rdata) !== mon_e.data) begin
            nerrors++;
            $display("[TB] FAIL rdata: got %h required %h", (mon_e.id ? m1_rdata : m0_rdata), mon_e.data);
          end
          nchecks++;
          if (cyc !== mon_e.due) begin
            nerrors++;
            $display("[TB] FAIL rvalid_cycle: got cycle %0d required %0d", cyc, mon_e.due);
          end
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        nchecks++;
        nerrors++;
        mon_e = sbq.pop_front();
        $display("[TB] FAIL missing_rvalid: no rvalid at cycle %0d for read due at %0d", cyc, mon_e.due);
      end
    end
  end

  // Run-time bound so the bench never hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_m0();
    m0_req = 1'b0; m0_lock = 1'b0; m0_we = 4'h0; m0_addr = '0; m0_wdata = '0;
  endtask

  task automatic idle_m1();
    m1_req = 1'b0; m1_lock = 1'b0; m1_we = 4'h0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic note_access(input logic id, input logic [3:0] we,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (we == 4'h0) begin
      sbq.push_back('{id: id, data: smem[addr[7:0]], due: cyc + 1 + RD_LAT});
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) smem[addr[7:0]][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  task automatic record_accepts(output logic a0, output logic a1);
    a0 = m0_req && m0_gnt;
    a1 = m1_req && m1_gnt;
    if (a0) note_access(1'b0, m0_we, m0_addr, m0_wdata);
    if (a1) note_access(1'b1, m1_we, m1_addr, m1_wdata);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sbq.delete();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] we_v;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    m0_req = 1'b1;
    m1_req = 1'b1;
    tick();
    tick();
    nchecks++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      nerrors++;
      $display("[TB] FAIL reset_gnt: got %b%b required 00", m0_gnt, m1_gnt);
    end
    we_v = bram_we;
    nchecks++;
    if (we_v !== 4'h0 || bram_addr !== 16'h0 || bram_din !== 32'h0) begin
      nerrors++;
      $display("[TB] FAIL reset_bram: got we=%h addr=%h din=%h required all 0", we_v, bram_addr, bram_din);
    end
    nchecks++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      nerrors++;
      $display("[TB] FAIL reset_rvalid: got %b%b required 00", m0_rvalid, m1_rvalid);
    end
    idle_m0();
    idle_m1();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    logic a0, a1;
    m0_req = 1'b1; m0_we = 4'hF; m0_addr = 16'h0010; m0_wdata = 32'hDEADBEEF;
    #1;
    nchecks++;
    if (m0_gnt !== 1'b1) begin
      nerrors++;
      $display("[TB] FAIL wr_gnt: got %b required 1", m0_gnt);
    end
    record_accepts(a0, a1);
    tick();
    idle_m0();
    nchecks++;
    if (bram_we !== 4'hF || bram_addr !== 16'h0010 || bram_din !== 32'hDEADBEEF) begin
      nerrors++;
      $display("[TB] FAIL wr_drive: got we=%h addr=%h din=%h required F/0010/DEADBEEF", bram_we, bram_addr, bram_din);
    end
    tick();
    nchecks++;
    if (bram_we !== 4'h0 || bram_addr !== 16'h0010) begin
      nerrors++;
      $display("[TB] FAIL wr_idle: got we=%h addr=%h required 0/0010", bram_we, bram_addr);
    end
  endtask

  task automatic test_single_read();
    logic a0, a1;
    m1_req = 1'b1; m1_we = 4'h0; m1_addr = 16'h0010;
    #1;
    nchecks++;
    if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
      nerrors++;
      $display("[TB] FAIL rd_gnt: got m0=%b m1=%b required 0/1", m0_gnt, m1_gnt);
    end
    record_accepts(a0, a1);
    tick();
    idle_m1();
    nchecks++;
    if (m1_rvalid !== 1'b0) begin
      nerrors++;
      $display("[TB] FAIL rd_early: got m1_rvalid=%b required 0 one cycle after accept", m1_rvalid);
    end
    tick();
    nchecks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEADBEEF || m0_rvalid !== 1'b0) begin
      nerrors++;
      $display("[TB] FAIL rd_return: got v1=%b data=%h v0=%b required 1/DEADBEEF/0", m1_rvalid, m1_rdata, m0_rvalid);
    end
    tick();
  endtask

  task automatic test_alternate();
    logic a0, a1;
    int   n0 = 0;
    int   n1 = 0;
    logic exp0;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      m0_req = 1'b1; m0_addr = 16'h0040 + 16'(n0);
      m0_we = (n0 % 2 == 1) ? 4'b0101 : 4'hF;
      m0_wdata = 32'hC0DE0000 + 32'(n0 * 32'h01010101);
      m1_req = 1'b1; m1_we = 4'h0; m1_addr = 16'h0040 + 16'(n1);
      #1;
      exp0 = (k % 2 == 0);
      nchecks++;
      if (m0_gnt !== exp0 || m1_gnt !== !exp0) begin
        nerrors++;
        $display("[TB] FAIL rr_alternate k=%0d: got m0=%b m1=%b required %b/%b", k, m0_gnt, m1_gnt, exp0, !exp0);
      end
      record_accepts(a0, a1);
      tick();
      if (a0) n0++;
      if (a1) n1++;
    end
    idle_m0();
    idle_m1();
  endtask

  task automatic test_lock_burst();
    logic a0, a1;
    for (int k = 0; k < 8; k++) begin
      m1_req = 1'b1; m1_lock = (k < 7); m1_we = 4'h0; m1_addr = 16'h0040 + 16'(k);
      m0_req = (k > 0); m0_we = 4'h0; m0_addr = 16'h0030;
      #1;
      nchecks++;
      if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1) begin
        nerrors++;
        $display("[TB] FAIL lock_hold k=%0d: got m0=%b m1=%b required 0/1", k, m0_gnt, m1_gnt);
      end
      record_accepts(a0, a1);
      tick();
    end
    idle_m1();
    #1;
    nchecks++;
    if (m0_gnt !== 1'b1) begin
      nerrors++;
      $display("[TB] FAIL lock_release: got m0_gnt=%b required 1", m0_gnt);
    end
    record_accepts(a0, a1);
    tick();
    idle_m0();
    tick();
  endtask

  task automatic test_timeout();
    logic a0, a1;
    for (int k = 0; k < 66; k++) begin
      m1_req = 1'b1; m1_lock = 1'b1; m1_we = 4'h0; m1_addr = 16'(k);
      m0_req = (k > 0); m0_we = 4'h0; m0_addr = 16'h0031;
      #1;
      if (k < 65) begin
        nchecks++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1) begin
          nerrors++;
          $display("[TB] FAIL timeout_own k=%0d: got m0=%b m1=%b required 0/1", k, m0_gnt, m1_gnt);
        end
      end else begin
        nchecks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
          nerrors++;
          $display("[TB] FAIL timeout_release: got m0=%b m1=%b required 1/0", m0_gnt, m1_gnt);
        end
      end
      record_accepts(a0, a1);
      tick();
    end
    idle_m0();
    idle_m1();
    tick();
  endtask

  task automatic test_reset_drop();
    logic a0, a1;
    m1_req = 1'b1; m1_we = 4'h0; m1_addr = 16'h0010;
    #1;
    nchecks++;
    if (m1_gnt !== 1'b1) begin
      nerrors++;
      $display("[TB] FAIL drop_gnt: got %b required 1", m1_gnt);
    end
    record_accepts(a0, a1);
    tick();
    rst_n = 1'b0;
    sbq.delete();
    m0_req = 1'b1; m1_we = 4'h0; m0_we = 4'h0; m0_addr = 16'h0011;
    #1;
    nchecks++;
    if (bram_we !== 4'h0 || bram_addr !== 16'h0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      nerrors++;
      $display("[TB] FAIL drop_reset: got we=%h addr=%h gnt=%b%b required 0/0000/00", bram_we, bram_addr, m0_gnt, m1_gnt);
    end
    tick();
    nchecks++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      nerrors++;
      $display("[TB] FAIL drop_rvalid: got %b%b required 00", m0_rvalid, m1_rvalid);
    end
    rst_n = 1'b1;
    #1;
    nchecks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      nerrors++;
      $display("[TB] FAIL drop_arb: got m0=%b m1=%b required 1/0", m0_gnt, m1_gnt);
    end
    record_accepts(a0, a1);
    tick();
    idle_m0();
    idle_m1();
  endtask

  // Test sequence.
  initial begin
    for (int i = 0; i < 256; i++) begin
      bmem[i] <= 32'hA5000000 | 32'(i);
      smem[i]  = 32'hA5000000 | 32'(i);
    end
    idle_m0();
    idle_m1();
    test_reset();
    test_single_write();
    test_single_read();
    test_alternate();
    test_lock_burst();
    test_timeout();
    test_reset_drop();
    repeat (5) tick();
    nchecks++;
    if (sbq.size() !== 0) begin
      nerrors++;
      $display("[TB] FAIL sb_drained: got %0d reads outstanding required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
